// File: rtl/dmem_dump_pkg.sv
// Shared types and constants for the data-memory dump controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_dump_pkg;

  localparam int WORD_BYTES       = 8;
  localparam int DEFAULT_DM_DEPTH = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_RD,
    S_SEND,
`ifdef DMEM_DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } dump_state_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Selects who drives the data-memory port: the core when idle, the dump controller when busy.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the core's store strobe is forced low while the controller owns the port.
module dmem_port_mux #(
  parameter int N = 64
) (
  input  logic         busy,
  input  logic [N-1:0] cpu_DM_addr,
  input  logic [N-1:0] cpu_DM_writeData,
  input  logic         cpu_DM_writeEnable,
  input  logic [N-1:0] ctrl_addr,
  output logic [N-1:0] DM_addr,
  output logic [N-1:0] DM_writeData,
  output logic         DM_writeEnable
);

  // Pass the core through unless a dump is in progress; then read-only controller access.
  always_comb begin
    DM_addr        = cpu_DM_addr;
    DM_writeData   = cpu_DM_writeData;
    DM_writeEnable = cpu_DM_writeEnable;
    if (busy) begin
      DM_addr        = ctrl_addr;
      DM_writeData   = '0;
      DM_writeEnable = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Halts the core on dump and streams every data-memory word out (optional checksum beat: DMEM_DUMP_CHECKSUM_EN).
// Latency: halt one cycle after dump is sampled, first beat valid two cycles later, then >=2 cycles per word.
// Backpressure: out_valid/out_data/out_last hold until out_ready; the dump simply waits in SEND.
module dmem_dump_ctrl
  import dmem_dump_pkg::*;
#(
  parameter int           N        = 64,
  parameter int           DM_DEPTH = DEFAULT_DM_DEPTH,
  parameter logic [N-1:0] DM_BASE  = '0
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         dump,
  input  logic [N-1:0] cpu_DM_addr,
  input  logic [N-1:0] cpu_DM_writeData,
  input  logic         cpu_DM_writeEnable,
  output logic [N-1:0] DM_addr,
  output logic [N-1:0] DM_writeData,
  output logic         DM_writeEnable,
  input  logic [N-1:0] DM_readData,
  output logic         cpu_halt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int IW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  dump_state_t   state, state_nxt;
  logic [IW-1:0] idx;
  logic          last_idx;
  logic [N-1:0]  ctrl_addr;

  assign last_idx  = (idx == IW'(DM_DEPTH - 1));
  assign ctrl_addr = DM_BASE + (N'(idx) << $clog2(WORD_BYTES));
  assign busy      = (state != S_IDLE);

  dmem_port_mux #(.N(N)) u_port_mux (
    .busy               (busy),
    .cpu_DM_addr        (cpu_DM_addr),
    .cpu_DM_writeData   (cpu_DM_writeData),
    .cpu_DM_writeEnable (cpu_DM_writeEnable),
    .ctrl_addr          (ctrl_addr),
    .DM_addr            (DM_addr),
    .DM_writeData       (DM_writeData),
    .DM_writeEnable     (DM_writeEnable)
  );

  // State register; reset aborts any dump in flight.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    cpu_halt  = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_halt = 1'b0;
        if (dump) state_nxt = S_HALT;
      end
      S_HALT: state_nxt = S_RD;
      S_RD:   state_nxt = S_SEND;
      S_SEND: begin
        out_valid = 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
        if (out_ready) state_nxt = last_idx ? S_CSUM : S_RD;
`else
        out_last = last_idx;
        if (out_ready) state_nxt = last_idx ? S_DONE : S_RD;
`endif
      end
`ifdef DMEM_DUMP_CHECKSUM_EN
      S_CSUM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        if (out_ready) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (!dump) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [N-1:0] csum;

  // Running mod-2^N sum of every word read during this dump.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)                csum <= '0;
    else if (state == S_HALT)  csum <= '0;
    else if (state == S_RD)    csum <= csum + DM_readData;
  end
`endif

  // Word index and beat payload; payload only changes in RD or after a handshake.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_HALT: idx <= '0;
        S_RD:   out_data <= DM_readData;
        S_SEND: begin
          if (out_ready) begin
            if (!last_idx) idx <= idx + 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
            else           out_data <= csum;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Randomized bench for dmem_dump_ctrl against a queue-based stream model and a shadow memory.
// Latency: checks start latency, full-dump length and DONE hold/release timing.
// Backpressure: exercises always-ready, toggling and random out_ready.
module tb_dmem_dump_ctrl;

  localparam int          N    = 64;
  localparam int          D    = 4;
  localparam logic [63:0] BASE = 64'h40;
  localparam int          BW   = 8;   // word index of BASE
`ifdef DMEM_DUMP_CHECKSUM_EN
  localparam int          CS   = 1;
`else
  localparam int          CS   = 0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          reset, dump, cpu_DM_writeEnable, DM_writeEnable;
  logic          cpu_halt, out_valid, out_ready, out_last, busy, done;
  logic [N-1:0]  cpu_DM_addr, cpu_DM_writeData, DM_addr, DM_writeData, DM_readData, out_data;

  logic [63:0]   mem       [64];
  logic [63:0]   model_mem [64];
  logic [63:0]   exp_q     [$];
  int            vectors = 0, errs = 0, beats_seen = 0, rmode = 0;
  logic          prev_stall = 1'b0, prev_last = 1'b0;
  logic [63:0]   prev_data = '0;

  always #10 CLOCK_50 = ~CLOCK_50;

  dmem_dump_ctrl #(.N(N), .DM_DEPTH(D), .DM_BASE(BASE)) dut (
    .CLOCK_50           (CLOCK_50),
    .reset              (reset),
    .dump               (dump),
    .cpu_DM_addr        (cpu_DM_addr),
    .cpu_DM_writeData   (cpu_DM_writeData),
    .cpu_DM_writeEnable (cpu_DM_writeEnable),
    .DM_addr            (DM_addr),
    .DM_writeData       (DM_writeData),
    .DM_writeEnable     (DM_writeEnable),
    .DM_readData        (DM_readData),
    .cpu_halt           (cpu_halt),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_last           (out_last),
    .busy               (busy),
    .done               (done)
  );

  // Data memory: combinational read, write on the clock.
  assign DM_readData = mem[DM_addr[8:3]];
  always @(posedge CLOCK_50) if (DM_writeEnable) mem[DM_addr[8:3]] = DM_writeData;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sink driver: always ready, toggling, or random.
  always @(posedge CLOCK_50) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Stream monitor: beats must match the model queue in order and hold while stalled.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data",  out_data,  prev_data);
        chk("hold_last",  out_last,  prev_last);
      end
      if (!out_valid) chk("last_without_valid", out_last, 0);
      if (out_valid && out_ready) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("beat_data", out_data, exp_q[0]);
          chk("beat_last", out_last, exp_q.size() == 1);
          void'(exp_q.pop_front());
        end
        beats_seen++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic load_stream();
    logic [63:0] sum = '0;
    exp_q.delete();
    beats_seen = 0;
    for (int i = 0; i < D; i++) begin
      exp_q.push_back(model_mem[BW + i]);
      sum += model_mem[BW + i];
    end
    if (CS == 1) exp_q.push_back(sum);
  endtask

  // One full dump; collide issues a core store on the request cycle and again while halted.
  task automatic do_dump(input int mode, input int hold, input bit collide);
    int j = 0;
    int first_v = -1;
    logic [63:0] wd;
    rmode = mode;
    @(negedge CLOCK_50);
    if (collide) begin
      wd = {$urandom, $urandom};
      cpu_DM_writeEnable = 1'b1;
      cpu_DM_addr        = BASE + 64'd8;
      cpu_DM_writeData   = wd;
      model_mem[BW + 1]  = wd;
    end
    load_stream();
    dump = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("halt_after_req", cpu_halt, 1);
    chk("busy_after_req", busy, 1);
    chk("we_blocked_halt", DM_writeEnable, 0);
    if (collide) begin
      cpu_DM_addr      = BASE + 64'd16;
      cpu_DM_writeData = {$urandom, $urandom};
    end
    while (!done && j < 400) begin
      if (out_valid && first_v < 0) first_v = j;
      if (collide) chk("we_blocked", DM_writeEnable, 0);
      @(negedge CLOCK_50);
      j++;
    end
    cpu_DM_writeEnable = 1'b0;
    chk("done_reached", done, 1);
    chk("first_valid_lat", first_v, 2);
    if (mode == 0) chk("done_latency", j, 2 * D + 1 + CS);
    chk("beats_left", exp_q.size(), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLOCK_50);
      chk("hold_done", done, 1);
      chk("hold_halt", cpu_halt, 1);
    end
    dump = 1'b0;
    @(negedge CLOCK_50);
    chk("idle_busy", busy, 0);
    chk("idle_halt", cpu_halt, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    reset = 1'b0; dump = 1'b0; out_ready = 1'b1;
    cpu_DM_writeEnable = 1'b0;
    cpu_DM_addr = 64'h1234_5678_9abc_def0; cpu_DM_writeData = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = {$urandom, $urandom};
      model_mem[i] = mem[i];
    end

    // Reset state.
    #5;
    chk("rst_halt",  cpu_halt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_addr_pass", DM_addr, 64'h1234_5678_9abc_def0);
    @(negedge CLOCK_50); reset = 1'b1;

    // Core pass-through store.
    @(negedge CLOCK_50);
    cpu_DM_addr = 64'h10; cpu_DM_writeData = 64'hDEAD; cpu_DM_writeEnable = 1'b1;
    #1;
    chk("pass_we",   DM_writeEnable, 1);
    chk("pass_addr", DM_addr, 64'h10);
    chk("pass_wd",   DM_writeData, 64'hDEAD);
    chk("pass_halt", cpu_halt, 0);
    model_mem[2] = 64'hDEAD;
    @(negedge CLOCK_50); cpu_DM_writeEnable = 1'b0;

    // Basic dump: words i+1.
    for (int i = 0; i < D; i++) begin
      mem[BW + i] = 64'(i + 1);
      model_mem[BW + i] = 64'(i + 1);
    end
    do_dump(0, 0, 0);

    // Toggling backpressure, then a store collision.
    do_dump(1, 0, 0);
    do_dump(0, 0, 1);
    chk("collide_word2", mem[BW + 2], model_mem[BW + 2]);

    // Reset during beat 2 aborts; next dump restarts at word 0.
    rmode = 0;
    @(negedge CLOCK_50);
    load_stream();
    dump = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(posedge CLOCK_50); #2;
      found = out_valid && (beats_seen == 1);
    end
    chk("abort_reached_beat2", found, 1);
    reset = 1'b0; dump = 1'b0;
    #1;
    chk("abort_halt",  cpu_halt, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_last",  out_last, 0);
    chk("abort_busy",  busy, 0);
    chk("abort_done",  done, 0);
    chk("abort_data",  out_data, 0);
    chk("abort_addr_pass", DM_addr, cpu_DM_addr);
    exp_q.delete();
    @(negedge CLOCK_50); #3 reset = 1'b1;
    do_dump(0, 0, 0);

    // Hold in DONE for 50 cycles.
    do_dump(0, 50, 0);

    // Randomized dumps.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < D; i++) begin
        mem[BW + i] = {$urandom, $urandom};
        model_mem[BW + i] = mem[BW + i];
      end
      do_dump(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 64; i++) chk("mem_final", mem[i], model_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
